// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared state encodings, defaults and requester indices for the multiplier scheduler
package mul_sched_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;
  localparam int W_DEF       = 16;
  localparam int LATENCY_DEF = 2;
  localparam int REQ_ALU     = 0;
  localparam int REQ_AUX     = 1;
  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/mul_sched_arb2.sv
// mul_sched_arb2: two-input arbiter; round-robin when MUL_SCHED_RR_EN is defined, else fixed priority to requester 0
module mul_sched_arb2 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       win
);
`ifdef MUL_SCHED_RR_EN
  logic last;
  // last-served pointer; resets to requester 1 so requester 0 wins the first tie
  always_ff @(posedge Clock) begin
    if (!Reset) last <= 1'b1;
    else if (update) last <= served;
  end
  // on a tie pick whoever was not served last, otherwise the only requester
  always_comb win = &req ? ~last : ~req[0];
`else
  logic unused;
  assign unused = ^{Clock, Reset, update, served, req[1]};
  // requester 0 always wins; win is only consumed when some request is present
  always_comb win = ~req[0];
`endif
endmodule

// File: rtl/mul_scheduler.sv
// mul_scheduler: arbitrates two requesters onto one external multiplier (round-robin under MUL_SCHED_RR_EN)
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic [0:0]     Clock,
  input  logic           Reset,
  input  logic [1:0]     iReq,
  input  logic [W-1:0]   iOpA0,
  input  logic [W-1:0]   iOpB0,
  input  logic [W-1:0]   iOpA1,
  input  logic [W-1:0]   iOpB1,
  output logic [1:0]     oGrant,
  output logic [1:0]     oDone,
  output logic [2*W-1:0] oResult,
  output logic           oBusy,
  output logic [W-1:0]   oMulA,
  output logic [W-1:0]   oMulB,
  output logic           oMulStart,
  input  logic [2*W-1:0] iMulResult
);
  state_t     state, state_nx;
  logic       win, win_q;
  logic [3:0] cnt;
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mul_scheduler: LATENCY must be in 1..15");
  end
  mul_sched_arb2 u_arb (
    .Clock  (Clock),
    .Reset  (Reset),
    .req    (iReq),
    .update (state == DONE),
    .served (win_q),
    .win    (win)
  );
  // state register
  always_ff @(posedge Clock) begin
    state <= !Reset ? IDLE : state_nx;
  end
  // next state: IDLE -> ISSUE -> WAIT (LATENCY cycles) -> DONE -> IDLE
  always_comb begin
    state_nx = state == IDLE  ? (|iReq ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (cnt == 4'd1 ? DONE : WAIT) : IDLE;
  end
  // pulses and busy decoded from state and the registered winner
  always_comb begin
    oGrant    = state == ISSUE ? onehot(win_q) : 2'b00;
    oMulStart = state == ISSUE;
    oDone     = state == DONE ? onehot(win_q) : 2'b00;
    oBusy     = state != IDLE;
  end
  // operand latch on arbitration, latency countdown, product capture
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      win_q   <= 1'b0;
      oMulA   <= '0;
      oMulB   <= '0;
      oResult <= '0;
      cnt     <= '0;
    end else begin
      if (state == IDLE && |iReq) begin
        win_q <= win;
        oMulA <= win ? iOpA1 : iOpA0;
        oMulB <= win ? iOpB1 : iOpB0;
      end
      if (state == ISSUE) cnt <= 4'(LATENCY);
      else if (state == WAIT) cnt <= cnt - 4'd1;
      if (state == WAIT && cnt == 4'd1) oResult <= iMulResult;
    end
  end
endmodule

// File: tb/tb_mul_scheduler.sv
// tb_mul_scheduler: directed bench for mul_scheduler with LATENCY 2, 1 and 15 instances sharing stimulus
module tb_mul_scheduler;
  logic        Clock = 1'b0;
  logic        Reset;
  logic [1:0]  iReq;
  logic [15:0] a0, b0, a1, b1;
  logic [1:0]  grant [3];
  logic [1:0]  done [3];
  logic [31:0] result [3];
  logic [31:0] mres [3];
  logic        busy [3];
  logic        start [3];
  logic [15:0] mula [3];
  logic [15:0] mulb [3];
  logic [31:0] pipe [3][1:15];
  logic        vld [3][1:15];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  function automatic int lat_of(input int d);
    return d == 0 ? 2 : d == 1 ? 1 : 15;
  endfunction

  mul_scheduler #(.W(16), .LATENCY(2)) dut (
    .Clock(Clock), .Reset(Reset), .iReq(iReq),
    .iOpA0(a0), .iOpB0(b0), .iOpA1(a1), .iOpB1(b1),
    .oGrant(grant[0]), .oDone(done[0]), .oResult(result[0]), .oBusy(busy[0]),
    .oMulA(mula[0]), .oMulB(mulb[0]), .oMulStart(start[0]), .iMulResult(mres[0]));
  mul_scheduler #(.W(16), .LATENCY(1)) dut_l1 (
    .Clock(Clock), .Reset(Reset), .iReq(iReq),
    .iOpA0(a0), .iOpB0(b0), .iOpA1(a1), .iOpB1(b1),
    .oGrant(grant[1]), .oDone(done[1]), .oResult(result[1]), .oBusy(busy[1]),
    .oMulA(mula[1]), .oMulB(mulb[1]), .oMulStart(start[1]), .iMulResult(mres[1]));
  mul_scheduler #(.W(16), .LATENCY(15)) dut_l15 (
    .Clock(Clock), .Reset(Reset), .iReq(iReq),
    .iOpA0(a0), .iOpB0(b0), .iOpA1(a1), .iOpB1(b1),
    .oGrant(grant[2]), .oDone(done[2]), .oResult(result[2]), .oBusy(busy[2]),
    .oMulA(mula[2]), .oMulB(mulb[2]), .oMulStart(start[2]), .iMulResult(mres[2]));

  // multiplier model: product appears exactly LATENCY cycles after the start cycle, garbage otherwise
  always @(posedge Clock) begin
    for (int d = 0; d < 3; d++) begin
      for (int j = 15; j >= 2; j--) begin
        pipe[d][j] <= pipe[d][j-1];
        vld[d][j]  <= Reset && vld[d][j-1];
      end
      pipe[d][1] <= 32'(mula[d]) * 32'(mulb[d]);
      vld[d][1]  <= Reset && start[d];
    end
  end
  always_comb begin
    for (int d = 0; d < 3; d++)
      mres[d] = vld[d][lat_of(d)] === 1'b1 ? pipe[d][lat_of(d)] : 32'hBAD0BAD0;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; iReq = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick(); tick();
    n_cmp++;
    if ({grant[0], done[0], start[0], busy[0]} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {grant[0], done[0], start[0], busy[0]});
    end
    n_cmp++;
    if (result[0] !== 32'h0) begin
      n_bad++; $display("FAIL reset_result: got %h want 00000000", result[0]);
    end
    n_cmp++;
    if ({mula[0], mulb[0]} !== 32'h0) begin
      n_bad++; $display("FAIL reset_operands: got %h want 00000000", {mula[0], mulb[0]});
    end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    a0 = 16'h0003; b0 = 16'h0005; iReq = 2'b01;
    tick();
    n_cmp++;
    if ({grant[0], start[0], busy[0]} !== 4'b0111) begin
      n_bad++; $display("FAIL single_grant: got grant=%b start=%b busy=%b want 01 1 1", grant[0], start[0], busy[0]);
    end
    n_cmp++;
    if ({mula[0], mulb[0]} !== {16'h0003, 16'h0005}) begin
      n_bad++; $display("FAIL single_operands: got %h want 00030005", {mula[0], mulb[0]});
    end
    iReq = 2'b00;
    tick();
    tick();
    n_cmp++;
    if (done[0] !== 2'b00) begin
      n_bad++; $display("FAIL single_early_done: got %b want 00", done[0]);
    end
    tick();
    n_cmp++;
    if (done[0] !== 2'b01 || result[0] !== 32'h0000000F) begin
      n_bad++; $display("FAIL single_done: got done=%b result=%h want 01 0000000f", done[0], result[0]);
    end
    tick();
    n_cmp++;
    if (busy[0] !== 1'b0 || done[0] !== 2'b00 || result[0] !== 32'h0000000F) begin
      n_bad++; $display("FAIL single_idle: got busy=%b done=%b result=%h want 0 00 0000000f", busy[0], done[0], result[0]);
    end
  endtask

  task automatic test_max();
    a1 = 16'hFFFF; b1 = 16'hFFFF; iReq = 2'b10;
    tick();
    n_cmp++;
    if (grant[0] !== 2'b10) begin
      n_bad++; $display("FAIL max_grant: got %b want 10", grant[0]);
    end
    iReq = 2'b00;
    tick(); tick(); tick();
    n_cmp++;
    if (done[0] !== 2'b10 || result[0] !== 32'hFFFE0001) begin
      n_bad++; $display("FAIL max_done: got done=%b result=%h want 10 fffe0001", done[0], result[0]);
    end
    tick();
  endtask

  task automatic test_contention();
    int ng = 0;
    int nd = 0;
    int prev = 0;
    logic [1:0] exp_g;
    a0 = 16'h0003; b0 = 16'h0005; a1 = 16'hFFFF; b1 = 16'hFFFF;
    iReq = 2'b11;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (grant[0] !== 2'b00) begin
`ifdef MUL_SCHED_RR_EN
        exp_g = ng % 2 == 0 ? 2'b01 : 2'b10;
`else
        exp_g = 2'b01;
`endif
        n_cmp++;
        if (grant[0] !== exp_g || c != (ng == 0 ? 1 : prev + 5)) begin
          n_bad++; $display("FAIL contention_grant%0d: got %b at cycle %0d want %b at cycle %0d", ng, grant[0], c, exp_g, ng == 0 ? 1 : prev + 5);
        end
        prev = c;
        ng++;
        if (ng == 4) iReq = 2'b00;
      end
      if (done[0] !== 2'b00) begin
        n_cmp++;
        if (result[0] !== (done[0] == 2'b10 ? 32'hFFFE0001 : 32'h0000000F)) begin
          n_bad++; $display("FAIL contention_result: got %h for done=%b", result[0], done[0]);
        end
        nd++;
      end
    end
    n_cmp++;
    if (ng != 4 || nd != 4 || busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL contention_count: got grants=%0d dones=%0d busy=%b want 4 4 0", ng, nd, busy[0]);
    end
  endtask

  task automatic test_operand_change();
    a0 = 16'h0003; b0 = 16'h0005; iReq = 2'b01;
    tick();
    n_cmp++;
    if (grant[0] !== 2'b01) begin
      n_bad++; $display("FAIL opchg_grant: got %b want 01", grant[0]);
    end
    iReq = 2'b00;
    tick();
    a0 = 16'h0007;
    tick();
    n_cmp++;
    if (mula[0] !== 16'h0003) begin
      n_bad++; $display("FAIL opchg_mula: got %h want 0003", mula[0]);
    end
    tick();
    n_cmp++;
    if (done[0] !== 2'b01 || result[0] !== 32'h0000000F) begin
      n_bad++; $display("FAIL opchg_result: got done=%b result=%h want 01 0000000f", done[0], result[0]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    a0 = 16'h0003; b0 = 16'h0005; iReq = 2'b01;
    tick();
    iReq = 2'b00;
    tick();
    n_cmp++;
    if (busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_busy: got %b want 1", busy[0]);
    end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    n_cmp++;
    if ({grant[0], done[0], start[0], busy[0], result[0], mula[0], mulb[0]} !== 70'b0) begin
      n_bad++; $display("FAIL rstmid_outputs: got grant=%b done=%b start=%b busy=%b result=%h a=%h b=%h want all zero", grant[0], done[0], start[0], busy[0], result[0], mula[0], mulb[0]);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (done[0] !== 2'b00) begin
        n_bad++; $display("FAIL rstmid_no_done: got %b want 00", done[0]);
      end
    end
    a0 = 16'h0002; b0 = 16'h0009; iReq = 2'b01;
    tick();
    n_cmp++;
    if (grant[0] !== 2'b01) begin
      n_bad++; $display("FAIL rstmid_regrant: got %b want 01", grant[0]);
    end
    iReq = 2'b00;
    tick(); tick(); tick();
    n_cmp++;
    if (done[0] !== 2'b01 || result[0] !== 32'h00000012) begin
      n_bad++; $display("FAIL rstmid_result: got done=%b result=%h want 01 00000012", done[0], result[0]);
    end
    tick();
  endtask

  task automatic test_latency();
    int at [3];
    logic [31:0] res [3];
    logic [1:0] dv [3];
    for (int d = 0; d < 3; d++) at[d] = -1;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    a0 = 16'h1234; b0 = 16'h0100; iReq = 2'b01;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 1) iReq = 2'b00;
      for (int d = 0; d < 3; d++) begin
        if (done[d] !== 2'b00 && at[d] < 0) begin
          at[d] = c; res[d] = result[d]; dv[d] = done[d];
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (at[d] != lat_of(d) + 2) begin
        n_bad++; $display("FAIL latency%0d_cycle: got done at %0d want %0d", lat_of(d), at[d], lat_of(d) + 2);
      end
      if (at[d] >= 0) begin
        n_cmp++;
        if (res[d] !== 32'h00123400 || dv[d] !== 2'b01) begin
          n_bad++; $display("FAIL latency%0d_result: got done=%b result=%h want 01 00123400", lat_of(d), dv[d], res[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_contention();
    test_operand_change();
    test_reset_mid();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
